// File: rtl/vga_pic_sched.sv
// Picture-change scheduler for the VGA pixel mux with frame-aligned fade out/in.
// Define PIC_SCHED_FADE_EN to enable fading; otherwise pictures swap directly.
module vga_pic_sched #(
    parameter int         NUM_PIC   = 2,
    parameter logic [7:0] FADE_STEP = 8'd16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_frame_start,
    input  logic       i_req_valid,
    input  logic [1:0] i_req_pic,
    output logic       o_req_ready,
    output logic [1:0] o_pic_sel,
    output logic [7:0] o_fade,
    output logic       o_busy,
    output logic       o_done,
    output logic       o_err
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        FADE_OUT = 2'd1,
        SWAP     = 2'd2,
        FADE_IN  = 2'd3
    } state_t;

    localparam logic [2:0] NPIC = 3'(NUM_PIC);

    state_t     r_state;
    logic [1:0] r_target;
    logic [1:0] r_pic_sel;
    logic       r_done;
    logic       r_err;
    logic       w_in_range;

    assign w_in_range = ({1'b0, i_req_pic} < NPIC);

`ifdef PIC_SCHED_FADE_EN
    logic [7:0] r_fade;
    logic [8:0] w_up;
    logic [7:0] w_inc;
    logic [7:0] w_dec;

    // Saturating step in both directions; 9-bit sum catches overflow past 255
    assign w_up  = {1'b0, r_fade} + {1'b0, FADE_STEP};
    assign w_inc = w_up[8] ? 8'hFF : w_up[7:0];
    assign w_dec = (r_fade > FADE_STEP) ? (r_fade - FADE_STEP) : 8'd0;
`else
    logic w_unused_step;
    assign w_unused_step = ^FADE_STEP;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_target  <= 2'd0;
            r_pic_sel <= 2'd0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
`ifdef PIC_SCHED_FADE_EN
            r_fade    <= 8'hFF;
`endif
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    if (i_req_valid) begin
                        if (!w_in_range) begin
                            r_err <= 1'b1;
                        end else if (i_req_pic == r_pic_sel) begin
                            r_done <= 1'b1;
                        end else begin
                            r_target <= i_req_pic;
`ifdef PIC_SCHED_FADE_EN
                            r_state  <= FADE_OUT;
`else
                            r_state  <= SWAP;
`endif
                        end
                    end
                end
`ifdef PIC_SCHED_FADE_EN
                FADE_OUT: begin
                    if (i_frame_start) begin
                        r_fade <= w_dec;
                        if (w_dec == 8'd0) begin
                            r_state <= SWAP;
                        end
                    end
                end
`endif
                SWAP: begin
                    if (i_frame_start) begin
                        r_pic_sel <= r_target;
`ifdef PIC_SCHED_FADE_EN
                        r_state   <= FADE_IN;
`else
                        r_state   <= IDLE;
                        r_done    <= 1'b1;
`endif
                    end
                end
`ifdef PIC_SCHED_FADE_EN
                FADE_IN: begin
                    if (i_frame_start) begin
                        r_fade <= w_inc;
                        if (w_inc == 8'hFF) begin
                            r_state <= IDLE;
                            r_done  <= 1'b1;
                        end
                    end
                end
`endif
                default: r_state <= IDLE;
            endcase
        end
    end

    assign o_req_ready = (r_state == IDLE);
    assign o_busy      = (r_state != IDLE);
    assign o_pic_sel   = r_pic_sel;
    assign o_done      = r_done;
    assign o_err       = r_err;
`ifdef PIC_SCHED_FADE_EN
    assign o_fade      = r_fade;
`else
    assign o_fade      = 8'hFF;
`endif

endmodule

// File: doc/vga_pic_sched.md
VGA_PIC_SCHED -- requirements
Module: vga_pic_sched

Interface
REQ-001 Parameter NUM_PIC, default 2, number of selectable pictures (1..4).
REQ-002 Parameter FADE_STEP, default 8'd16, brightness change applied per frame during a fade (1..255).
REQ-003 clk  input  1  pixel clock, shared with the VGA timing block; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 i_frame_start  input  1  one-cycle pulse at start of each vertical sync; all fade/swap steps align to it.
REQ-006 i_req_valid  input  1  requester presents a picture-change request.
REQ-007 i_req_pic  input  2  requested picture index.
REQ-008 o_req_ready  output  1  request is accepted on the cycle where valid and ready are both high.
REQ-009 o_pic_sel  output  2  picture index driving the VGA pixel memory mux.
REQ-010 o_fade  output  8  brightness scale for the VGA colour path; 255 is full brightness, 0 is black.
REQ-011 o_busy  output  1  high whenever state is not IDLE.
REQ-012 o_done  output  1  one-cycle pulse when a request completes.
REQ-013 o_err  output  1  one-cycle pulse when an out-of-range request is dropped.

Function
REQ-014 The FSM has states IDLE, FADE_OUT, SWAP and FADE_IN; o_req_ready is 1 only in IDLE.
REQ-015 IDLE handshake, in-range index differing from o_pic_sel: latch the target, enter FADE_OUT next cycle.
REQ-016 IDLE handshake, index equal to o_pic_sel: stay in IDLE, pulse o_done on the next cycle, no fade.
REQ-017 IDLE handshake, index >= NUM_PIC: drop the request, pulse o_err on the next cycle, no state or output change.
REQ-018 Valid while not ready: no effect; the request is neither stored nor queued, and the requester holds it until ready.
REQ-019 FADE_OUT: on each i_frame_start, o_fade becomes max(o_fade - FADE_STEP, 0); the update that reaches 0 moves the FSM to SWAP in the same cycle.
REQ-020 SWAP: on the next i_frame_start, o_pic_sel takes the latched target and the FSM enters FADE_IN.
REQ-021 FADE_IN: on each i_frame_start, o_fade becomes min(o_fade + FADE_STEP, 255), computed 9-bit and saturated; the update that reaches 255 moves the FSM to IDLE and pulses o_done in the same cycle.
REQ-022 An i_frame_start coincident with an accepted request in IDLE is not consumed; the first fade step occurs at the following i_frame_start.
REQ-023 o_pic_sel changes only in SWAP at an i_frame_start, never mid-frame.
REQ-024 Without i_frame_start pulses, the FSM holds its state and outputs indefinitely.

Reset
REQ-025 Asserting rst at any time, including mid-fade, immediately forces state IDLE, o_pic_sel=0, o_fade=255, o_busy=0, o_done=0, o_err=0 and clears the latched target.
REQ-026 After rst deasserts, the first request is acceptable in the first clock cycle.

Configuration
REQ-027 Macro PIC_SCHED_FADE_EN defined: fade behaviour is as given in REQ-019..REQ-021.
REQ-028 Macro PIC_SCHED_FADE_EN undefined:
  - o_fade is tied to 255.
  - FADE_OUT and FADE_IN are not implemented.
  - An accepted differing request goes IDLE -> SWAP.
  - At the next i_frame_start, o_pic_sel updates, o_done pulses and the FSM returns to IDLE.

Verification
REQ-029 FADE_STEP=64, fade enabled, request pic 1 from pic 0 -> o_fade 191, 127, 63, 0 on frames 1-4; o_pic_sel=1 on frame 5; o_fade 64, 128, 192, 255 on frames 6-9; o_done pulses once at frame 9; o_busy high throughout.
REQ-030 Request pic 0 while o_pic_sel=0 -> o_done pulse one cycle later, o_busy stays 0, o_fade stays 255.
REQ-031 NUM_PIC=2, request pic 3 -> o_err pulse one cycle later, o_pic_sel unchanged, state IDLE.
REQ-032 i_req_valid held high during FADE_OUT with a different index -> o_req_ready=0 and no effect; the request is accepted on the first IDLE cycle after o_done.
REQ-033 rst pulse during FADE_IN at o_fade=128 -> o_fade=255, o_pic_sel=0 and o_busy=0 immediately, without waiting for a clock edge.
REQ-034 Fade disabled, request pic 1 -> o_pic_sel=1 and o_done pulse at the first subsequent i_frame_start; o_fade constant 255.
